// File: rtl/uart_loader.sv
// UART 8N1 receiver feeding a byte-wise memory loader (SPRAM byte wrapper port).
// Optional macro UART_LOADER_EOT_EN: a received 0x04 terminates the load early.
module uart_loader #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUD     = 9600,
    parameter int LOAD_LEN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic        start,
    output logic [14:0] mem_addr,
    output logic        mem_write,
    output logic [7:0]  mem_data_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] byte_count,
    output logic        frame_err
);

    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);
    localparam logic [15:0]      LEN_LAST  = 16'(LOAD_LEN);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
    typedef enum logic [1:0] {L_IDLE, L_ARMED, L_WRITE} l_state_t;

    // rx_prev_reg holds the previous synchronized level for falling-edge detection
    logic rx_meta_reg, rx_sync_reg, rx_prev_reg;

    r_state_t         r_state_reg, r_state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shreg_reg, shreg_next;
    logic             rx_valid_reg, rx_valid_next;
    logic             rx_ferr_reg, rx_ferr_next;

    l_state_t    l_state_reg, l_state_next;
    logic [14:0] addr_reg, addr_next;
    logic        write_reg, write_next;
    logic [7:0]  data_reg, data_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic [15:0] count_reg, count_next;
    logic        ferr_reg, ferr_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_reg  <= 1'b1;
            rx_sync_reg  <= 1'b1;
            rx_prev_reg  <= 1'b1;
            r_state_reg  <= R_IDLE;
            cnt_reg      <= '0;
            bit_reg      <= '0;
            shreg_reg    <= '0;
            rx_valid_reg <= 1'b0;
            rx_ferr_reg  <= 1'b0;
        end else begin
            rx_meta_reg  <= rx;
            rx_sync_reg  <= rx_meta_reg;
            rx_prev_reg  <= rx_sync_reg;
            r_state_reg  <= r_state_next;
            cnt_reg      <= cnt_next;
            bit_reg      <= bit_next;
            shreg_reg    <= shreg_next;
            rx_valid_reg <= rx_valid_next;
            rx_ferr_reg  <= rx_ferr_next;
        end
    end

    always_comb begin
        r_state_next  = r_state_reg;
        cnt_next      = cnt_reg;
        bit_next      = bit_reg;
        shreg_next    = shreg_reg;
        rx_valid_next = 1'b0;
        rx_ferr_next  = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                if (rx_prev_reg && !rx_sync_reg) begin
                    r_state_next = R_START;
                    cnt_next     = '0;
                    bit_next     = '0;
                end
            end
            R_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next     = '0;
                    r_state_next = rx_sync_reg ? R_IDLE : R_DATA;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            R_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    shreg_next = {rx_sync_reg, shreg_reg[7:1]};
                    if (bit_reg == 3'd7)
                        r_state_next = R_STOP;
                    else
                        bit_next = bit_reg + 3'd1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            R_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next      = '0;
                    rx_valid_next = rx_sync_reg;
                    rx_ferr_next  = !rx_sync_reg;
                    r_state_next  = R_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            l_state_reg <= L_IDLE;
            addr_reg    <= '0;
            write_reg   <= 1'b0;
            data_reg    <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            count_reg   <= '0;
            ferr_reg    <= 1'b0;
        end else begin
            l_state_reg <= l_state_next;
            addr_reg    <= addr_next;
            write_reg   <= write_next;
            data_reg    <= data_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            count_reg   <= count_next;
            ferr_reg    <= ferr_next;
        end
    end

    always_comb begin
        l_state_next = l_state_reg;
        addr_next    = addr_reg;
        write_next   = write_reg;
        data_next    = data_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        count_next   = count_reg;
        ferr_next    = ferr_reg | rx_ferr_reg;
        case (l_state_reg)
            L_IDLE: begin
                if (start) begin
                    l_state_next = L_ARMED;
                    addr_next    = '0;
                    count_next   = '0;
                    busy_next    = 1'b1;
                    ferr_next    = 1'b0;
                end
            end
            L_ARMED: begin
                if (rx_valid_reg) begin
`ifdef UART_LOADER_EOT_EN
                    if (shreg_reg == 8'h04) begin
                        done_next    = 1'b1;
                        busy_next    = 1'b0;
                        l_state_next = L_IDLE;
                    end else begin
                        data_next    = shreg_reg;
                        write_next   = 1'b1;
                        l_state_next = L_WRITE;
                    end
`else
                    data_next    = shreg_reg;
                    write_next   = 1'b1;
                    l_state_next = L_WRITE;
`endif
                end
            end
            L_WRITE: begin
                write_next = 1'b0;
                count_next = count_reg + 16'd1;
                // the final address is never incremented, so 0x7FFF does not wrap
                if (count_reg + 16'd1 == LEN_LAST) begin
                    done_next    = 1'b1;
                    busy_next    = 1'b0;
                    l_state_next = L_IDLE;
                end else begin
                    addr_next    = addr_reg + 15'd1;
                    l_state_next = L_ARMED;
                end
            end
            default: l_state_next = L_IDLE;
        endcase
    end

    assign mem_addr    = addr_reg;
    assign mem_write   = write_reg;
    assign mem_data_in = data_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign byte_count  = count_reg;
    assign frame_err   = ferr_reg;

endmodule
